// File: rtl/sw_pkg.sv
// Shared constants and types for the slide-switch debouncer.
// Imported by the per-bit debouncer and the bus-level top.
package sw_pkg;

    localparam int SW_WIDTH             = 10;
    localparam int SW_STABLE_CYCLES_DEF = 50000;
    localparam int SW_CNT_W             = 16;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, mismatch counter, two-state FSM
// and a one-cycle change flag raised when a new level is accepted.
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEF,
    parameter int CNT_W         = SW_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic accept_o,
    output logic changed_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             q1_q, q2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed_q, changed_d;
    db_state_e        state_q, state_d;
    logic             mismatch;

    // NOTE: every flop, synchroniser included, is reset so that a change in
    // flight when reset hits is fully discarded and must be recounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so q2 takes the old q1, not this edge's sample.
            q1_q <= raw_i;
            q2_q <= q1_q;
        end
    end

    assign mismatch = q2_q ^ stable_q;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        changed_d = 1'b0;
        case (state_q)
            DB_IDLE: begin
                // Counter is 0 here and STABLE_CYCLES >= 2, so no acceptance yet.
                if (mismatch) begin
                    state_d = DB_COUNT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DB_COUNT: begin
                if (!mismatch) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DB_IDLE;
                    cnt_d     = '0;
                    stable_d  = q2_q;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DB_IDLE;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
        end
    end

    assign stable_o  = stable_q;
    assign accept_o  = changed_d;
    assign changed_o = changed_q;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioning ahead of the 4:1 mux: per-bit sync + debounce,
// plus a registered strobe and mask of the bits accepted on the last edge.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = SW_STABLE_CYCLES_DEF,
    parameter int CNT_W         = SW_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw,
    output logic             sw_changed,
    output logic [WIDTH-1:0] sw_changed_mask
);

    logic [WIDTH-1:0] accept;
    logic             sw_changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst),
            .raw_i    (sw_raw[i]),
            .stable_o (sw[i]),
            .accept_o (accept[i]),
            .changed_o(sw_changed_mask[i])
        );
    end

    // Registered from the same next-state flags as the mask, so both align.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_changed_q <= 1'b0;
        end else begin
            sw_changed_q <= |accept;
        end
    end

    assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with STABLE_CYCLES = 4: expected change
// pulses are queued when stimulus is driven and matched when the DUT strobes.
module tb_sw_debounce;

    localparam int W   = 10;
    localparam int SC  = 4;
    localparam int LAT = SC + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw;
    logic         sw_changed;
    logic [W-1:0] sw_changed_mask;

    int edge_cnt = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int           edge_n;
        logic [W-1:0] sw_v;
        logic [W-1:0] mask_v;
    } exp_t;

    exp_t exp_q[$];

    sw_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_raw         (sw_raw),
        .sw             (sw),
        .sw_changed     (sw_changed),
        .sw_changed_mask(sw_changed_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at the negedge where sw_raw is driven: the change lands LAT edges later.
    task automatic expect_change(input logic [W-1:0] sw_v, input logic [W-1:0] mask_v);
        exp_t e;
        e.edge_n = edge_cnt + LAT;
        e.sw_v   = sw_v;
        e.mask_v = mask_v;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sw_changed) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(sw_changed), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_edge", edge_cnt, e.edge_n);
                check("pulse_sw", 32'(sw), 32'(e.sw_v));
                check("pulse_mask", 32'(sw_changed_mask), 32'(e.mask_v));
            end
        end else begin
            if (sw_changed_mask != '0)
                check("mask_without_pulse", 32'(sw_changed_mask), 32'd0);
            if (exp_q.size() != 0 && exp_q[0].edge_n <= edge_cnt) begin
                e = exp_q.pop_front();
                check("missing_pulse", 32'(sw_changed), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sw_raw = '1;
        rst    = 1'b0;
        step(2);
        check("rst_sw", 32'(sw), 32'd0);
        check("rst_changed", 32'(sw_changed), 32'd0);
        check("rst_mask", 32'(sw_changed_mask), 32'd0);

        // Release with all switches high: nothing for 5 edges, then all accepted.
        rst = 1'b1;
        expect_change(10'h3FF, 10'h3FF);
        for (int i = 0; i < LAT - 1; i++) begin
            step(1);
            check("release_sw_hold", 32'(sw), 32'd0);
        end
        step(1);
        check("release_sw", 32'(sw), 32'h3FF);
        sw_raw = '0;
        expect_change(10'h000, 10'h3FF);
        step(LAT + 2);
        check("clear_sw", 32'(sw), 32'd0);

        // Clean single-bit change.
        sw_raw = 10'h001;
        expect_change(10'h001, 10'h001);
        step(LAT - 1);
        check("clean_sw_before", 32'(sw), 32'd0);
        step(1);
        check("clean_sw", 32'(sw), 32'h001);
        check("clean_changed", 32'(sw_changed), 32'd1);
        step(1);
        check("clean_changed_drop", 32'(sw_changed), 32'd0);
        check("clean_sw_hold", 32'(sw), 32'h001);
        step(2);

        // Two-cycle glitch on bit 3 must be rejected.
        sw_raw[3] = 1'b1;
        step(2);
        sw_raw[3] = 1'b0;
        step(12);
        check("glitch_sw", 32'(sw), 32'h001);

        // Bounce on bit 9: 1,0,1,0,1 then held high.
        for (int i = 0; i < 5; i++) begin
            sw_raw[9] = (i % 2 == 0);
            if (i == 4) expect_change(10'h201, 10'h200);
            else step(1);
        end
        step(LAT - 1);
        check("bounce_sw_before", 32'(sw), 32'h001);
        step(1);
        check("bounce_sw", 32'(sw), 32'h201);
        step(3);

        // Back to zero, then two bits change on the same edge.
        sw_raw = '0;
        expect_change(10'h000, 10'h201);
        step(LAT + 2);
        sw_raw = 10'h300;
        expect_change(10'h300, 10'h300);
        step(LAT + 2);
        check("simul_sw", 32'(sw), 32'h300);

        // Reset two edges into a held change: the count restarts from scratch.
        sw_raw = 10'h005;
        step(2);
        rst = 1'b0;
        #1;
        check("midrst_sw", 32'(sw), 32'd0);
        check("midrst_changed", 32'(sw_changed), 32'd0);
        check("midrst_mask", 32'(sw_changed_mask), 32'd0);
        step(2);
        rst = 1'b1;
        expect_change(10'h005, 10'h005);
        step(LAT - 1);
        check("midrst_sw_before", 32'(sw), 32'd0);
        step(1);
        check("midrst_sw_after", 32'(sw), 32'h005);
        step(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
